// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// memory-busy hold with watchdog and saturating counters. Optional macro: HAZARD_BRANCH_ID_EN.
module hazard_unit #(
    parameter int CNT_W      = 16,
    parameter int HOLD_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_WriteReg,
    input  logic             Branch_Taken,
    input  logic             Mem_Busy,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Pipe_Hold,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic             Hold_Timeout
);

    typedef enum logic [1:0] {
        CLS_RUN    = 2'd0,
        CLS_BUBBLE = 2'd1,
        CLS_HOLD   = 2'd2,
        CLS_FLUSH  = 2'd3
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(HOLD_LIMIT - 1);

    // Operand match against a producer; $0 is never a real dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic uses,
                                       input logic [4:0] dst);
        return uses && (dst != 5'd0) && (src == dst);
    endfunction

    logic             lu_hit_s;
    logic             br_hit_s;
    cls_t             cls_s;
    cls_t             state_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic             timeout_r;

    assign lu_hit_s = ID_EX_MemRead && ID_EX_RegWrite &&
                      (reg_match(ID_Rs, ID_UsesRs, ID_EX_WriteReg) ||
                       reg_match(ID_Rt, ID_UsesRt, ID_EX_WriteReg));

`ifdef HAZARD_BRANCH_ID_EN
    // Branch compares in ID need both operands final: wait on ALU results in EX and loads in MEM.
    assign br_hit_s = ID_Branch &&
                      ((ID_EX_RegWrite &&
                        (reg_match(ID_Rs, ID_UsesRs, ID_EX_WriteReg) ||
                         reg_match(ID_Rt, ID_UsesRt, ID_EX_WriteReg))) ||
                       (EX_MEM_MemRead &&
                        (reg_match(ID_Rs, ID_UsesRs, EX_MEM_WriteReg) ||
                         reg_match(ID_Rt, ID_UsesRt, EX_MEM_WriteReg))));
`else
    logic unused_br_s;
    assign unused_br_s = ^{ID_Branch, EX_MEM_MemRead, EX_MEM_WriteReg};
    assign br_hit_s    = 1'b0;
`endif

    // Cycle classification; memory hold outranks everything, taken branches lose to stalls.
    always_comb begin
        cls_s = CLS_RUN;
        if (Mem_Busy) begin
            cls_s = CLS_HOLD;
        end else if (lu_hit_s || br_hit_s) begin
            cls_s = CLS_BUBBLE;
        end else if (Branch_Taken) begin
            cls_s = CLS_FLUSH;
        end else begin
            cls_s = CLS_RUN;
        end
    end

    // Pipeline controls decoded from the class; reset forces the free-running values.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Pipe_Hold   = 1'b0;
        if (reset) begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
        end else begin
            case (cls_s)
                CLS_HOLD: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Hold   = 1'b1;
                end
                CLS_BUBBLE: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
                CLS_FLUSH: begin
                    IF_ID_Flush = 1'b1;
                end
                default: begin
                    PC_Write    = 1'b1;
                    IF_ID_Write = 1'b1;
                end
            endcase
        end
    end

    // Previous-cycle class register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CLS_RUN;
        end else begin
            state_r <= cls_s;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (((cls_s == CLS_BUBBLE) || (cls_s == CLS_HOLD)) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if ((cls_s == CLS_FLUSH) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    // Hold watchdog: consecutive-hold run length and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_r <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else if (cls_s == CLS_HOLD) begin
            if (run_cnt_r != CNT_MAX) begin
                run_cnt_r <= run_cnt_r + CNT_ONE;
            end
            if (run_cnt_r >= RUN_LAST) begin
                timeout_r <= 1'b1;
            end
        end else begin
            run_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign State        = state_r;
    assign Stall_Cnt    = stall_cnt_r;
    assign Flush_Cnt    = flush_cnt_r;
    assign Hold_Timeout = timeout_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares. A second instance with CNT_W=2 checks saturation.
module tb_hazard_unit;

`ifdef HAZARD_BRANCH_ID_EN
    localparam bit BR_ID = 1'b1;
`else
    localparam bit BR_ID = 1'b0;
`endif

    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_BUB = 5'b00010;
    localparam logic [4:0] C_HLD = 5'b00001;
    localparam logic [4:0] C_FLU = 5'b11100;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, ID_EX_WriteReg, EX_MEM_WriteReg;
    logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_EX_MemRead, ID_EX_RegWrite;
    logic       EX_MEM_MemRead, Branch_Taken, Mem_Busy;

    logic       pc_w, ifid_w, ifid_f, idex_f, hold, tmo;
    logic [1:0] st;
    logic [7:0] stall_c, flush_c;
    logic       s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_hold, s_tmo;
    logic [1:0] s_st;
    logic [1:0] s_stall_c, s_flush_c;

    hazard_unit #(.CNT_W(8), .HOLD_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteReg(EX_MEM_WriteReg), .Branch_Taken(Branch_Taken), .Mem_Busy(Mem_Busy),
        .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f), .ID_EX_Flush(idex_f),
        .Pipe_Hold(hold), .State(st), .Stall_Cnt(stall_c), .Flush_Cnt(flush_c),
        .Hold_Timeout(tmo)
    );

    hazard_unit #(.CNT_W(2), .HOLD_LIMIT(3)) dut_sat (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteReg(EX_MEM_WriteReg), .Branch_Taken(Branch_Taken), .Mem_Busy(Mem_Busy),
        .PC_Write(s_pc_w), .IF_ID_Write(s_ifid_w), .IF_ID_Flush(s_ifid_f),
        .ID_EX_Flush(s_idex_f), .Pipe_Hold(s_hold), .State(s_st), .Stall_Cnt(s_stall_c),
        .Flush_Cnt(s_flush_c), .Hold_Timeout(s_tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [4:0] ctrl;
        logic [1:0] st;
        int         stall;
        int         flush;
        bit         tmo;
        bit         s_tmo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp_v);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Monitor: compare the oldest expectation against both instances at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.nm, "ctrl", 32'({pc_w, ifid_w, ifid_f, idex_f, hold}), 32'(mon_e.ctrl));
            chk(mon_e.nm, "state", 32'(st), 32'(mon_e.st));
            chk(mon_e.nm, "stall", 32'(stall_c), 32'(mon_e.stall));
            chk(mon_e.nm, "flush", 32'(flush_c), 32'(mon_e.flush));
            chk(mon_e.nm, "tmo", 32'(tmo), 32'(mon_e.tmo));
            chk(mon_e.nm, "s_ctrl", 32'({s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_hold}),
                32'(mon_e.ctrl));
            chk(mon_e.nm, "s_state", 32'(s_st), 32'(mon_e.st));
            chk(mon_e.nm, "s_stall", 32'(s_stall_c), 32'(sat3(mon_e.stall)));
            chk(mon_e.nm, "s_flush", 32'(s_flush_c), 32'(sat3(mon_e.flush)));
            chk(mon_e.nm, "s_tmo", 32'(s_tmo), 32'(mon_e.s_tmo));
        end
    end

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_WriteReg = 5'd0;
        EX_MEM_MemRead = 1'b0; EX_MEM_WriteReg = 5'd0; Branch_Taken = 1'b0; Mem_Busy = 1'b0;
    endtask

    task automatic load_in_ex(input logic [4:0] wr);
        ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_WriteReg = wr;
    endtask

    // Queue the expectation for the inputs now applied, then advance one cycle.
    task automatic step(input string nm, input logic [4:0] ctrl, input logic [1:0] est,
                        input int es, input int ef, input bit et, input bit est_tmo);
        exp_t e;
        e.nm = nm; e.ctrl = ctrl; e.st = est; e.stall = es; e.flush = ef;
        e.tmo = et; e.s_tmo = est_tmo;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        load_in_ex(5'd8); ID_Rs = 5'd8; ID_UsesRs = 1'b1;
        step("reset_forces_run", C_RUN, 2'd0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        step("load_use", C_BUB, 2'd0, 0, 0, 1'b0, 1'b0);
        idle();
        step("after_bubble", C_RUN, 2'd1, 1, 0, 1'b0, 1'b0);
        load_in_ex(5'd0); ID_Rs = 5'd0; ID_UsesRs = 1'b1;
        step("reg0_no_hit", C_RUN, 2'd0, 1, 0, 1'b0, 1'b0);
        idle(); load_in_ex(5'd8); ID_Rs = 5'd3; ID_UsesRs = 1'b1; ID_Rt = 5'd8;
        step("rt_unused", C_RUN, 2'd0, 1, 0, 1'b0, 1'b0);
        ID_UsesRt = 1'b1; Branch_Taken = 1'b1;
        step("rt_hit_branch_ignored", C_BUB, 2'd0, 1, 0, 1'b0, 1'b0);
        Mem_Busy = 1'b1;
        step("hold1", C_HLD, 2'd1, 2, 0, 1'b0, 1'b0);
        step("hold2", C_HLD, 2'd2, 3, 0, 1'b0, 1'b0);
        step("hold3", C_HLD, 2'd2, 4, 0, 1'b0, 1'b0);
        idle();
        step("gap", C_RUN, 2'd2, 5, 0, 1'b0, 1'b1);
        Mem_Busy = 1'b1;
        step("burst2_1", C_HLD, 2'd0, 5, 0, 1'b0, 1'b1);
        step("burst2_2", C_HLD, 2'd2, 6, 0, 1'b0, 1'b1);
        step("burst2_3", C_HLD, 2'd2, 7, 0, 1'b0, 1'b1);
        step("burst2_4", C_HLD, 2'd2, 8, 0, 1'b0, 1'b1);
        idle();
        step("timeout_set", C_RUN, 2'd2, 9, 0, 1'b1, 1'b1);
        Branch_Taken = 1'b1;
        step("flush1", C_FLU, 2'd0, 9, 0, 1'b1, 1'b1);
        idle();
        step("after_flush", C_RUN, 2'd3, 9, 1, 1'b1, 1'b1);
        Branch_Taken = 1'b1;
        step("flush2", C_FLU, 2'd0, 9, 1, 1'b1, 1'b1);
        step("flush3", C_FLU, 2'd3, 9, 2, 1'b1, 1'b1);
        step("flush4", C_FLU, 2'd3, 9, 3, 1'b1, 1'b1);
        step("flush5", C_FLU, 2'd3, 9, 4, 1'b1, 1'b1);
        idle();
        step("flush_total", C_RUN, 2'd3, 9, 5, 1'b1, 1'b1);
        // load r9 in EX, beq reading r9 in ID
        load_in_ex(5'd9); ID_Branch = 1'b1; ID_Rs = 5'd9; ID_UsesRs = 1'b1;
        step("ld_br_1", C_BUB, 2'd0, 9, 5, 1'b1, 1'b1);
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_WriteReg = 5'd0;
        EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd9;
        step("ld_br_2", BR_ID ? C_BUB : C_RUN, 2'd1, 10, 5, 1'b1, 1'b1);
        EX_MEM_MemRead = 1'b0; EX_MEM_WriteReg = 5'd0;
        step("ld_br_go", C_RUN, BR_ID ? 2'd1 : 2'd0, BR_ID ? 11 : 10, 5, 1'b1, 1'b1);
        load_in_ex(5'd9);
        step("ld_br_again", C_BUB, 2'd0, BR_ID ? 11 : 10, 5, 1'b1, 1'b1);
        ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0; ID_EX_WriteReg = 5'd0;
        EX_MEM_MemRead = 1'b1; EX_MEM_WriteReg = 5'd9; reset = 1'b1;
        step("reset_mid_stall", C_RUN, 2'd1, BR_ID ? 12 : 11, 5, 1'b1, 1'b1);
        reset = 1'b0;
        step("fresh_after_reset", BR_ID ? C_BUB : C_RUN, 2'd0, 0, 0, 1'b0, 1'b0);
        idle();
        step("settle", C_RUN, BR_ID ? 2'd1 : 2'd0, BR_ID ? 1 : 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (sb_q.size() > 0) begin
                @(posedge clk);
            end
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush controller for the 5-stage pipeline; it complements the EX-stage forwarding unit. It detects the hazards forwarding cannot resolve (load-use, and optionally branch-in-ID operand hazards), freezes or bubbles the front end, and flushes wrong-path fetches on taken branches. It also owns the pipeline hold for a busy memory, with a hold watchdog and stall/flush performance counters.

## Interface
- CNT_W, 16: width of the performance counters.
- HOLD_LIMIT, 255: consecutive hold cycles before the watchdog fires (1 to 2^CNT_W-1).
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is sampled on the rising edge of clk.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction actually reads Rs/Rt.
- ID_Branch  in  1  the ID instruction is a branch or jr.
- ID_EX_MemRead, ID_EX_RegWrite  in  1 each  the EX-stage instruction is a load / writes a register.
- ID_EX_WriteReg  in  5  destination register of the EX-stage instruction.
- EX_MEM_MemRead  in  1  the MEM-stage instruction is a load.
- EX_MEM_WriteReg  in  5  destination register of the MEM-stage instruction.
- Branch_Taken  in  1  redirect this cycle (EX-resolved, or ID-resolved when the macro is set).
- Mem_Busy  in  1  the data memory cannot complete this cycle.
- PC_Write  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero the IF/ID register.
- ID_EX_Flush  out  1  insert a bubble into ID/EX.
- Pipe_Hold  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
- State  out  2  classification of the previous cycle: 0 RUN, 1 BUBBLE, 2 HOLD, 3 FLUSH.
- Stall_Cnt, Flush_Cnt  out  CNT_W each  saturating event counters.
- Hold_Timeout  out  1  sticky watchdog flag.

## Operation
- Register matches ignore register $0.
- lu_hit is asserted when all of the following hold:
  - ID_EX_MemRead and ID_EX_RegWrite are both high;
  - ID_EX_WriteReg is nonzero;
  - ID_EX_WriteReg matches Rs with UsesRs, or Rt with UsesRt.
- br_hit is asserted only when HAZARD_BRANCH_ID_EN is defined; see Configuration.
- Each cycle takes one class, in priority order:
  - HOLD if Mem_Busy;
  - else BUBBLE if lu_hit or br_hit;
  - else FLUSH if Branch_Taken;
  - else RUN.
- Outputs per class:
  - RUN: PC_Write=1, IF_ID_Write=1, all other controls 0.
  - HOLD: PC_Write=0, IF_ID_Write=0, Pipe_Hold=1, both flushes 0.
  - BUBBLE: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - FLUSH: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1.
- Branch_Taken during BUBBLE or HOLD is ignored. The source re-presents it once the stall clears.
- State register: State takes the current cycle's class at the rising edge.
- Counters:
  - Stall_Cnt increments on each BUBBLE or HOLD cycle.
  - Flush_Cnt increments on each FLUSH cycle.
  - Both saturate at all-ones and never wrap.
- Watchdog:
  - An internal run counter counts consecutive HOLD cycles and clears on any non-HOLD cycle.
  - When the run count reaches HOLD_LIMIT, Hold_Timeout is set.
  - Hold_Timeout stays set until reset. Holding continues regardless; the watchdog only flags.

## Timing
- Control outputs (PC_Write, IF_ID_Write, flushes, Pipe_Hold) are combinational, with zero latency from the inputs. They must be settled before the rising edge that would load the pipeline registers.
- State, the counters and Hold_Timeout are registered and reflect the previous cycle one edge later.
- While reset is high, controls are forced to RUN values. At the edge: State=0, Stall_Cnt=0, Flush_Cnt=0, run counter 0, Hold_Timeout=0.
- Reset mid-stall aborts the stall. The next cycle is classified fresh from the inputs.
- Load-use costs exactly 1 BUBBLE cycle. In the following cycle the load is in MEM and forwarding covers it.
- Hold_Timeout is first visible in the cycle after the HOLD_LIMIT-th consecutive HOLD cycle.

## Configuration
- HAZARD_BRANCH_ID_EN defined: branches resolve in ID. br_hit is asserted when ID_Branch is high and a source register (Rs with UsesRs, or Rt with UsesRt) matches either:
  - ID_EX_WriteReg, with ID_EX_RegWrite high and the register nonzero; or
  - EX_MEM_WriteReg, with EX_MEM_MemRead high and the register nonzero.
- Consequences: an ALU-to-branch dependency costs 1 bubble; a load-to-branch dependency costs 2 bubbles (lu_hit, then br_hit).
- HAZARD_BRANCH_ID_EN undefined: br_hit is held at 0 and branches resolve in EX.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_RegWrite=1, ID_EX_WriteReg=8, ID_Rs=8, ID_UsesRs=1 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle State=1 and Stall_Cnt=1.
- $0 and unused operand:
  - the same load with WriteReg=0 and Rs=0 -> RUN;
  - Rt=8 with UsesRt=0 -> RUN.
- Mem_Busy held with lu_hit=1 and Branch_Taken=1 -> HOLD outputs only (Pipe_Hold=1, both flushes 0); Stall_Cnt increments by 1 per cycle.
- Watchdog: HOLD_LIMIT=4, Mem_Busy high for 3 cycles, low for 1, then high for 4 -> Hold_Timeout stays 0 after the first burst and is 1 in the cycle after the 4th cycle of the second burst; it remains 1 until reset.
- Taken branch alone -> IF_ID_Flush=1 and PC_Write=1 for 1 cycle, Flush_Cnt=1. With CNT_W=2, 5 flushes -> Flush_Cnt=3 (saturated).
- With HAZARD_BRANCH_ID_EN: a load to r9 followed by a beq reading r9 -> exactly 2 BUBBLE cycles, then RUN; reset asserted during the second bubble -> controls return to RUN values and all registered outputs are 0.
